// File: rtl/spi_cs_arbiter_if.sv
// Bundle of requester-side and engine-side signals around the SPI chip-select arbiter.
// The slave modport is the arbiter's view; master is the view of requesters plus engine.
interface spi_cs_arbiter_if #(
  parameter int NumReq = 4
);
  logic [NumReq-1:0]   req_tx_valid_i;
  logic [8*NumReq-1:0] req_tx_data_i;
  logic [NumReq-1:0]   req_tx_last_i;
  logic [NumReq-1:0]   req_tx_ready_o;
  logic [NumReq-1:0]   req_rx_valid_o;
  logic [7:0]          req_rx_data_o;
  logic [NumReq-1:0]   gnt_o;
  logic                eng_tx_valid_o;
  logic [7:0]          eng_tx_data_o;
  logic                eng_tx_ready_i;
  logic                eng_rx_valid_i;
  logic [7:0]          eng_rx_data_i;
  logic                eng_idle_i;
  logic [NumReq-1:0]   cs_no;

  modport master (
    output req_tx_valid_i, req_tx_data_i, req_tx_last_i,
    output eng_tx_ready_i, eng_rx_valid_i, eng_rx_data_i, eng_idle_i,
    input  req_tx_ready_o, req_rx_valid_o, req_rx_data_o, gnt_o,
    input  eng_tx_valid_o, eng_tx_data_o, cs_no
  );

  modport slave (
    input  req_tx_valid_i, req_tx_data_i, req_tx_last_i,
    input  eng_tx_ready_i, eng_rx_valid_i, eng_rx_data_i, eng_idle_i,
    output req_tx_ready_o, req_rx_valid_o, req_rx_data_o, gnt_o,
    output eng_tx_valid_o, eng_tx_data_o, cs_no
  );
endinterface

// File: rtl/spi_cs_arbiter.sv
// Round-robin owner of one SPI byte engine; each grant covers a whole CS-low transaction
// with programmable setup, hold and inter-transaction gap around it.
module spi_cs_arbiter #(
  parameter int NumReq        = 4,
  parameter int CsSetupCycles = 4,
  parameter int CsHoldCycles  = 4,
  parameter int CsGapCycles   = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  spi_cs_arbiter_if.slave bus
);
  localparam int IdxW   = $clog2(NumReq);
  localparam int MaxSH  = (CsSetupCycles > CsHoldCycles) ? CsSetupCycles : CsHoldCycles;
  localparam int MaxCyc = (MaxSH > CsGapCycles) ? MaxSH : CsGapCycles;
  localparam int CntW   = (MaxCyc > 0) ? $clog2(MaxCyc + 1) : 1;
  localparam logic [CntW-1:0] SetupLast = CntW'(CsSetupCycles - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(CsHoldCycles - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(CsGapCycles - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, ACTIVE, CS_HOLD, CS_GAP} state_t;

  state_t            r_state;
  logic [CntW-1:0]   r_cnt;
  logic [IdxW-1:0]   r_ptr;
  logic [IdxW-1:0]   r_gidx;
  logic [NumReq-1:0] r_gnt;
  logic [NumReq-1:0] r_cs_n;
  logic              r_last_seen;

  logic              w_pick_vld;
  logic [IdxW-1:0]   w_pick;
  logic [NumReq-1:0] w_pick_oh;
  int                w_scan;
  logic [7:0]        w_data;
  logic              w_active;
  logic              w_open;
  logic              w_accept;
  logic              w_last_g;
  logic              w_release;
  logic [IdxW-1:0]   w_ptr_next;

  // First pending requester at or after the pointer, wrapping upward.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = '0;
    w_scan     = 0;
    for (int i = 0; i < NumReq; i++) begin
      w_scan = (int'(r_ptr) + i) % NumReq;
      if (!w_pick_vld && bus.req_tx_valid_i[w_scan]) begin
        w_pick_vld = 1'b1;
        w_pick     = IdxW'(w_scan);
      end
    end
  end

  assign w_pick_oh = {{(NumReq-1){1'b0}}, 1'b1} << w_pick;

  always_comb begin
    w_data = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (r_gidx == IdxW'(i)) w_data = bus.req_tx_data_i[8*i +: 8];
    end
  end

  // Once the last byte is taken the owner may already be presenting its next request.
  assign w_active   = (r_state == ACTIVE);
  assign w_open     = w_active && !r_last_seen;
  assign w_last_g   = |(bus.req_tx_last_i & r_gnt);
  assign w_accept   = bus.eng_tx_valid_o && bus.eng_tx_ready_i;
  assign w_ptr_next = (r_gidx == IdxW'(NumReq - 1)) ? '0 : r_gidx + IdxW'(1);
  assign w_release  = (w_active && r_last_seen && bus.eng_idle_i && (CsHoldCycles == 0)) ||
                      ((r_state == CS_HOLD) && (r_cnt == HoldLast));

  assign bus.eng_tx_valid_o = w_open && |(bus.req_tx_valid_i & r_gnt);
  assign bus.eng_tx_data_o  = w_data;
  assign bus.req_tx_ready_o = w_open ? (r_gnt & {NumReq{bus.eng_tx_ready_i}}) : '0;
  assign bus.req_rx_valid_o = w_active ? (r_gnt & {NumReq{bus.eng_rx_valid_i}}) : '0;
  assign bus.req_rx_data_o  = bus.eng_rx_data_i;
  assign bus.gnt_o          = r_gnt;
  assign bus.cs_no          = r_cs_n;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_gidx      <= '0;
      r_gnt       <= '0;
      r_cs_n      <= '1;
      r_last_seen <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_pick_vld) begin
          r_gidx      <= w_pick;
          r_gnt       <= w_pick_oh;
          r_cs_n      <= ~w_pick_oh;
          r_last_seen <= 1'b0;
          r_cnt       <= '0;
          r_state     <= (CsSetupCycles == 0) ? ACTIVE : CS_SETUP;
        end
        CS_SETUP: if (r_cnt == SetupLast) begin
          r_cnt   <= '0;
          r_state <= ACTIVE;
        end else begin
          r_cnt <= r_cnt + CntW'(1);
        end
        ACTIVE: begin
          if (w_accept && w_last_g) r_last_seen <= 1'b1;
          if (r_last_seen && bus.eng_idle_i && (CsHoldCycles != 0)) begin
            r_cnt   <= '0;
            r_state <= CS_HOLD;
          end
        end
        CS_HOLD: r_cnt <= r_cnt + CntW'(1);
        CS_GAP: if (r_cnt == GapLast) begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt + CntW'(1);
        end
        default: r_state <= IDLE;
      endcase
      // Release overrides the per-state updates above for the leaving cycle.
      if (w_release) begin
        r_gnt   <= '0;
        r_cs_n  <= '1;
        r_ptr   <= w_ptr_next;
        r_cnt   <= '0;
        r_state <= (CsGapCycles == 0) ? IDLE : CS_GAP;
      end
    end
  end

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(r_gnt));
  a_cs_matches: assert property (@(posedge clk_i) disable iff (rst_i) (~r_cs_n) == r_gnt);
  a_tx_active:  assert property (@(posedge clk_i) disable iff (rst_i)
                                 bus.eng_tx_valid_o |-> (r_state == ACTIVE));
endmodule

// File: tb/tb_spi_cs_arbiter.sv
// Bench for spi_cs_arbiter: timeline model checked every cycle plus directed literal checks.
module tb_spi_cs_arbiter;
  localparam int N  = 4;
  localparam int SU = 4;
  localparam int HO = 4;
  localparam int GA = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_cs_arbiter_if #(.NumReq(N)) bus ();
  spi_cs_arbiter_if #(.NumReq(N)) zb ();

  spi_cs_arbiter #(.NumReq(N), .CsSetupCycles(SU), .CsHoldCycles(HO), .CsGapCycles(GA))
    dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  spi_cs_arbiter #(.NumReq(N), .CsSetupCycles(0), .CsHoldCycles(0), .CsGapCycles(0))
    dut_z (.clk_i(clk), .rst_i(rst), .bus(zb));

  logic       tv [N];
  logic       tl [N];
  logic [7:0] td [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      bus.req_tx_valid_i[k]       = tv[k];
      bus.req_tx_last_i[k]        = tl[k];
      bus.req_tx_data_i[8*k +: 8] = td[k];
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: wait expired, got no event want event (cycle %0d)", nm, cyc);
  endtask

  // Model: a transaction is a timeline of edges -- grant, active start, hold start, release.
  int m_own = -1, m_ptr = 0, m_tact = 0, m_tcond = -1, m_trel = -1, m_next = 0, m_k = 0;
  bit m_ls = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_own = -1; m_ptr = 0; m_ls = 1'b0; m_tcond = -1; m_trel = -1; m_next = cyc + 1;
    end else if (m_own < 0) begin
      if (cyc >= m_next) begin
        for (int i = 0; i < N; i++) begin
          m_k = (m_ptr + i) % N;
          if (m_own < 0 && tv[m_k]) m_own = m_k;
        end
        if (m_own >= 0) begin
          m_tact = cyc + SU; m_ls = 1'b0; m_tcond = -1; m_trel = -1;
        end
      end
    end else begin
      if (cyc - 1 >= m_tact && m_tcond < 0) begin
        if (m_ls && bus.eng_idle_i) begin
          m_tcond = cyc; m_trel = cyc + HO;
        end else if (!m_ls && tv[m_own] && tl[m_own] && bus.eng_tx_ready_i) begin
          m_ls = 1'b1;
        end
      end
      if (m_trel == cyc) begin
        m_ptr = (m_own + 1) % N; m_own = -1; m_next = cyc + GA + 1;
      end
    end
  end

  logic [N-1:0] e_oh, e_cs;
  bit e_act, e_open, e_txv;
  always @(negedge clk) begin
    if (chk_on) begin
      e_oh   = (m_own >= 0) ? N'(1 << m_own) : '0;
      e_cs   = ~e_oh;
      e_act  = (m_own >= 0) && (cyc >= m_tact) && (m_tcond < 0);
      e_open = e_act && !m_ls;
      e_txv  = e_open && tv[m_own];
      chk("gnt", 32'(bus.gnt_o), 32'(e_oh));
      chk("cs", 32'(bus.cs_no), 32'(e_cs));
      chk("eng_txv", 32'(bus.eng_tx_valid_o), 32'(e_txv));
      if (e_txv) chk("eng_txd", 32'(bus.eng_tx_data_o), 32'(td[m_own]));
      chk("ready", 32'(bus.req_tx_ready_o), 32'((e_open && bus.eng_tx_ready_i) ? e_oh : '0));
      chk("rxv", 32'(bus.req_rx_valid_o), 32'((e_act && bus.eng_rx_valid_i) ? e_oh : '0));
      chk("rxd", 32'(bus.req_rx_data_o), 32'(bus.eng_rx_data_i));
    end
  end

  // Grant log and all-CS-high cycles preceding each grant.
  int gq[$];
  int gapq[$];
  int gapc = 0;
  logic [N-1:0] pg = '0;
  always @(negedge clk) begin
    if (chk_on) begin
      if (bus.gnt_o == '0) gapc++;
      if (pg == '0 && bus.gnt_o != '0) begin
        for (int i = 0; i < N; i++) if (bus.gnt_o[i]) gq.push_back(i);
        gapq.push_back(gapc);
        gapc = 0;
      end
      pg = bus.gnt_o;
    end
  end

  // Engine: one byte takes three busy cycles after acceptance.
  int busy = 0;
  bit acc;
  initial begin
    bus.eng_tx_ready_i = 1'b1;
    bus.eng_idle_i     = 1'b1;
    forever begin
      @(negedge clk);
      acc = bus.eng_tx_valid_o && bus.eng_tx_ready_i;
      @(posedge clk);
      #1;
      if (rst) busy = 0;
      else if (acc) busy = 3;
      else if (busy > 0) busy--;
      bus.eng_tx_ready_i = (busy == 0);
      bus.eng_idle_i     = (busy == 0);
    end
  end

  task automatic send(input int k, input int n, input logic [7:0] b0, input bit keep);
    int w;
    for (int i = 0; i < n; i++) begin
      tv[k] = 1'b1; td[k] = b0 + 8'(i); tl[k] = (i == n - 1);
      w = 0;
      forever begin
        @(negedge clk);
        if (bus.req_tx_ready_o[k]) break;
        w++;
        if (w > 500) break;
      end
      if (w > 500) begin
        timeout("send_accept");
        tv[k] = 1'b0; tl[k] = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    if (keep) begin td[k] = 8'hEE; tl[k] = 1'b0; end
    else begin tv[k] = 1'b0; tl[k] = 1'b0; end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (!(m_own < 0 && cyc >= m_next && bus.gnt_o == '0) && w < 400) begin
      @(negedge clk); w++;
    end
    if (w >= 400) timeout("drain");
    @(posedge clk); #1;
  endtask

  task automatic wait_neg_cs(input int k, input logic lvl, output int at);
    int w;
    w = 0; at = -1;
    while (w < 300) begin
      @(negedge clk);
      if (bus.cs_no[k] == lvl) begin at = cyc; break; end
      w++;
    end
    if (at < 0) timeout("wait_cs");
  endtask

  int s, v, a, b, i_t, r, w;

  initial begin
    for (int k = 0; k < N; k++) begin tv[k] = 1'b0; tl[k] = 1'b0; td[k] = 8'h00; end
    bus.eng_rx_valid_i = 1'b0; bus.eng_rx_data_i = 8'h00;
    zb.req_tx_valid_i = '0; zb.req_tx_data_i = '0; zb.req_tx_last_i = '0;
    zb.eng_tx_ready_i = 1'b1; zb.eng_rx_valid_i = 1'b0; zb.eng_rx_data_i = 8'h00;
    zb.eng_idle_i = 1'b1;
    @(posedge clk); #1;
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", 32'(bus.cs_no), 32'h0000_000F);
    chk("rst_gnt", 32'(bus.gnt_o), 32'h0);
    chk("rst_txv", 32'(bus.eng_tx_valid_o), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Simultaneous requests 0,2,3 from pointer 0.
    s = gq.size();
    fork
      send(0, 1, 8'h10, 1'b0);
      send(2, 1, 8'h20, 1'b0);
      send(3, 1, 8'h30, 1'b0);
    join
    drain();
    chk("rr_count", 32'(gq.size() - s), 32'd3);
    if (gq.size() >= s + 3) begin
      chk("rr_first", 32'(gq[s]), 32'd0);
      chk("rr_second", 32'(gq[s+1]), 32'd2);
      chk("rr_third", 32'(gq[s+2]), 32'd3);
      chk("rr_gap1", 32'(gapq[s+1] >= 2), 32'd1);
      chk("rr_gap2", 32'(gapq[s+2] >= 2), 32'd1);
    end

    // Req1 three bytes: setup and hold timing.
    v = cyc;
    fork
      send(1, 3, 8'h40, 1'b0);
      begin
        wait_neg_cs(1, 1'b0, a);
        chk("cs_low_latency", 32'(a - v), 32'd1);
        b = -1; w = 0;
        while (w < 100) begin
          @(negedge clk);
          if (bus.eng_tx_valid_o) begin b = cyc; break; end
          w++;
        end
        if (b < 0) timeout("first_txv"); else chk("setup_to_txv", 32'(b - a), 32'(SU));
        w = 0;
        while (!(tv[1] && tl[1] && bus.req_tx_ready_o[1]) && w < 300) begin @(negedge clk); w++; end
        @(negedge clk);
        i_t = -1; w = 0;
        while (w < 100) begin
          if (bus.eng_idle_i) begin i_t = cyc; break; end
          @(negedge clk); w++;
        end
        wait_neg_cs(1, 1'b1, r);
        if (i_t < 0) timeout("idle_rise"); else chk("idle_to_cs_high", 32'(r - i_t), 32'(HO + 1));
      end
    join
    drain();

    // Req1 keeps requesting; req0 must be served before req1 again.
    s = gq.size();
    fork
      send(1, 2, 8'h50, 1'b1);
      begin repeat (3) @(posedge clk); #1; send(0, 1, 8'h60, 1'b0); end
    join
    send(1, 1, 8'h70, 1'b0);
    drain();
    if (gq.size() >= s + 3) begin
      chk("fair_first", 32'(gq[s]), 32'd1);
      chk("fair_second", 32'(gq[s+1]), 32'd0);
      chk("fair_third", 32'(gq[s+2]), 32'd1);
    end else timeout("fair_grants");

    // RX routing to req2; strobe during hold is dropped.
    fork
      send(2, 2, 8'h80, 1'b0);
      begin
        w = 0;
        while (w < 200) begin
          @(negedge clk);
          if (bus.eng_tx_valid_o && bus.gnt_o == 4'b0100) break;
          w++;
        end
        if (w >= 200) timeout("rx_window");
        @(posedge clk); #1;
        bus.eng_rx_valid_i = 1'b1; bus.eng_rx_data_i = 8'hA5;
        @(negedge clk);
        chk("rx_route", 32'(bus.req_rx_valid_o), 32'h4);
        chk("rx_data", 32'(bus.req_rx_data_o), 32'hA5);
        @(posedge clk); #1;
        bus.eng_rx_valid_i = 1'b0;
        w = 0;
        while (!(m_own == 2 && m_tcond >= 0) && w < 300) begin @(negedge clk); w++; end
        if (w >= 300) timeout("hold_window");
        @(posedge clk); #1;
        bus.eng_rx_valid_i = 1'b1; bus.eng_rx_data_i = 8'h5A;
        @(negedge clk);
        chk("rx_hold_drop", 32'(bus.req_rx_valid_o), 32'h0);
        chk("hold_cs", 32'(bus.cs_no), 32'hB);
        @(posedge clk); #1;
        bus.eng_rx_valid_i = 1'b0;
      end
    join
    drain();

    // Reset in the middle of a 4-byte transaction from req3.
    tv[3] = 1'b1; td[3] = 8'h90; tl[3] = 1'b0;
    w = 0;
    while (w < 200) begin
      @(negedge clk);
      if (bus.req_tx_ready_o[3]) break;
      w++;
    end
    if (w >= 200) timeout("rst_first_byte");
    @(posedge clk); #1;
    td[3] = 8'h91;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_cs", 32'(bus.cs_no), 32'hF);
    chk("midrst_gnt", 32'(bus.gnt_o), 32'h0);
    chk("midrst_ready", 32'(bus.req_tx_ready_o), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; tv[3] = 1'b0;
    s = gq.size();
    fork
      send(1, 1, 8'hA0, 1'b0);
      send(3, 1, 8'hB0, 1'b0);
    join
    drain();
    if (gq.size() >= s + 2) begin
      chk("postrst_first", 32'(gq[s]), 32'd1);
      chk("postrst_second", 32'(gq[s+1]), 32'd3);
    end else timeout("postrst_grants");

    // Zero setup/hold/gap instance.
    zb.req_tx_valid_i = 4'b0001; zb.req_tx_data_i = 32'h0000_00C3; zb.req_tx_last_i = 4'b0001;
    @(negedge clk);
    chk("z_cs_before", 32'(zb.cs_no), 32'hF);
    @(posedge clk); #1;
    @(negedge clk);
    chk("z_cs_low", 32'(zb.cs_no), 32'hE);
    chk("z_gnt", 32'(zb.gnt_o), 32'h1);
    chk("z_txv", 32'(zb.eng_tx_valid_o), 32'h1);
    chk("z_txd", 32'(zb.eng_tx_data_o), 32'hC3);
    chk("z_ready", 32'(zb.req_tx_ready_o), 32'h1);
    @(posedge clk); #1;
    zb.req_tx_valid_i = '0; zb.req_tx_last_i = '0; zb.eng_idle_i = 1'b0;
    @(negedge clk);
    chk("z_txv_after_last", 32'(zb.eng_tx_valid_o), 32'h0);
    chk("z_cs_busy", 32'(zb.cs_no), 32'hE);
    @(posedge clk); #1;
    zb.eng_idle_i = 1'b1;
    @(negedge clk);
    chk("z_cs_idle_rise", 32'(zb.cs_no), 32'hE);
    @(posedge clk); #1;
    @(negedge clk);
    chk("z_cs_release", 32'(zb.cs_no), 32'hF);
    chk("z_gnt_release", 32'(zb.gnt_o), 32'h0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
